right_shift_aligner: RTL and testbench

- Pipelined logarithmic right shifter with valid/ready handshake on both sides.
- Used for operand alignment ahead of the adder: shifts the smaller operand right by the exponent/position difference.
- Performs the opposite-direction operation to the existing left barrel shifter, which handles post-add normalization.
- One mux stage per pipeline register; accepts one operand per cycle; reports a sticky bit for bits shifted out.

---
 rtl/right_shift_aligner.sv | 98 +++++++++
 tb/tb_right_shift_aligner.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/right_shift_aligner.sv
// right_shift_aligner: pipelined logarithmic right shifter, one mux level per stage, global-stall handshake.
// Define RSA_STICKY_EN to add the Sticky output (OR of every bit shifted out).
module right_shift_aligner #(
    parameter int N = 32
) (
    input  logic                 Clock,
    input  logic                 Reset_n,
    input  logic [N-1:0]         In,
    input  logic [$clog2(N)-1:0] ShiftAmount,
    input  logic                 ShiftIn,
    input  logic                 InValid,
    output logic                 InReady,
    output logic [N-1:0]         Out,
`ifdef RSA_STICKY_EN
    output logic                 Sticky,
`endif
    output logic                 OutValid,
    input  logic                 OutReady
);
    localparam int nSel = $clog2(N);

    logic            advance;
    logic [nSel:0]   vld_pipe;
    logic [N-1:0]    data_pipe [0:nSel];
    logic [nSel-1:0] amt_pipe  [0:nSel-1];
    logic [nSel-1:0] fill_pipe;
`ifdef RSA_STICKY_EN
    logic [nSel:0]   sticky_pipe;
    assign sticky_pipe[0] = 1'b0;
`endif

    assign vld_pipe[0]  = InValid;
    assign data_pipe[0] = In;
    assign amt_pipe[0]  = ShiftAmount;
    assign fill_pipe[0] = ShiftIn;

    // Whole pipe moves together; it only stops when the output slot is full and not taken.
    assign advance = OutReady | ~vld_pipe[nSel];
    assign InReady = advance;

    for (genvar s = 1; s <= nSel; s++) begin : stage_g
        localparam int SH = 1 << (nSel - s);
        logic         sel;
        logic [N-1:0] shifted;
        logic         vld_q;
        logic [N-1:0] data_q;

        // Amount travels MSB-first: each stage consumes the top bit and shifts the rest up.
        assign sel     = amt_pipe[s-1][nSel-1];
        assign shifted = sel ? {{SH{fill_pipe[s-1]}}, data_pipe[s-1][N-1:SH]} : data_pipe[s-1];

        always_ff @(posedge Clock or negedge Reset_n) begin
            if (!Reset_n) begin
                vld_q  <= 1'b0;
                data_q <= '0;
            end else if (advance) begin
                vld_q  <= vld_pipe[s-1];
                data_q <= vld_pipe[s-1] ? shifted : '0;
            end
        end
        assign vld_pipe[s]  = vld_q;
        assign data_pipe[s] = data_q;

        if (s < nSel) begin : carry_g
            logic [nSel-1:0] amt_q;
            logic            fill_q;
            always_ff @(posedge Clock or negedge Reset_n) begin
                if (!Reset_n) begin
                    amt_q  <= '0;
                    fill_q <= 1'b0;
                end else if (advance) begin
                    amt_q  <= vld_pipe[s-1] ? (amt_pipe[s-1] << 1) : '0;
                    fill_q <= vld_pipe[s-1] ? fill_pipe[s-1] : 1'b0;
                end
            end
            assign amt_pipe[s]  = amt_q;
            assign fill_pipe[s] = fill_q;
        end

`ifdef RSA_STICKY_EN
        logic dropped;
        logic sticky_q;
        assign dropped = sel & (|data_pipe[s-1][SH-1:0]);
        always_ff @(posedge Clock or negedge Reset_n) begin
            if (!Reset_n)     sticky_q <= 1'b0;
            else if (advance) sticky_q <= vld_pipe[s-1] ? (sticky_pipe[s-1] | dropped) : 1'b0;
        end
        assign sticky_pipe[s] = sticky_q;
`endif
    end

    assign Out      = data_pipe[nSel];
    assign OutValid = vld_pipe[nSel];
`ifdef RSA_STICKY_EN
    assign Sticky   = sticky_pipe[nSel];
`endif

endmodule

// File: tb/tb_right_shift_aligner.sv
// Directed bench for right_shift_aligner: vector table, streaming stall, and mid-flight reset.
module tb_right_shift_aligner;
    localparam int N = 32;

    logic         Clock = 1'b0;
    logic         Reset_n;
    logic [N-1:0] In;
    logic [4:0]   ShiftAmount;
    logic         ShiftIn;
    logic         InValid;
    logic         InReady;
    logic [N-1:0] Out;
`ifdef RSA_STICKY_EN
    logic         Sticky;
`endif
    logic         OutValid;
    logic         OutReady;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] in;
        logic [4:0]  amt;
        logic        fill;
        logic [31:0] exp_out;
        logic        exp_sticky;
    } vec_t;

    vec_t vecs [10];
    logic [31:0] got [$];

    right_shift_aligner #(.N(N)) dut (
        .Clock(Clock),
        .Reset_n(Reset_n),
        .In(In),
        .ShiftAmount(ShiftAmount),
        .ShiftIn(ShiftIn),
        .InValid(InValid),
        .InReady(InReady),
        .Out(Out),
`ifdef RSA_STICKY_EN
        .Sticky(Sticky),
`endif
        .OutValid(OutValid),
        .OutReady(OutReady)
    );

    always #5 Clock = ~Clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Send one operand, then measure latency and compare the result.
    task automatic run_vec(input string name, input vec_t v);
        int lat;
        @(negedge Clock);
        In = v.in; ShiftAmount = v.amt; ShiftIn = v.fill; InValid = 1'b1;
        #1 check({name, " in_ready"}, 32'(InReady), 32'd1);
        @(posedge Clock); #1;
        InValid = 1'b0; In = '0; ShiftAmount = '0; ShiftIn = 1'b0;
        lat = 1;
        while (!OutValid && lat < 12) begin
            @(posedge Clock); #1;
            lat++;
        end
        check({name, " latency"}, 32'(lat), 32'd5);
        check({name, " out"}, Out, v.exp_out);
`ifdef RSA_STICKY_EN
        check({name, " sticky"}, 32'(Sticky), 32'(v.exp_sticky));
`endif
        @(posedge Clock); #1;
    endtask

    initial begin
        logic        acc;
        logic        saw;
        logic [31:0] held;

        vecs[0] = '{32'h8000_0000, 5'd31, 1'b0, 32'h0000_0001, 1'b0};
        vecs[1] = '{32'h0000_00FF, 5'd4,  1'b0, 32'h0000_000F, 1'b1};
        vecs[2] = '{32'h0000_00FF, 5'd0,  1'b0, 32'h0000_00FF, 1'b0};
        vecs[3] = '{32'h0000_0000, 5'd8,  1'b1, 32'hFF00_0000, 1'b0};
        vecs[4] = '{32'hF000_0010, 5'd4,  1'b1, 32'hFF00_0001, 1'b0};
        vecs[5] = '{32'hDEAD_BEEF, 5'd16, 1'b0, 32'h0000_DEAD, 1'b1};
        vecs[6] = '{32'h8000_0001, 5'd1,  1'b1, 32'hC000_0000, 1'b1};
        vecs[7] = '{32'h0000_0000, 5'd31, 1'b1, 32'hFFFF_FFFE, 1'b0};
        vecs[8] = '{32'hFFFF_FFFF, 5'd31, 1'b0, 32'h0000_0001, 1'b1};
        vecs[9] = '{32'h1234_5678, 5'd12, 1'b0, 32'h0001_2345, 1'b1};

        Reset_n = 1'b0; In = '0; ShiftAmount = '0; ShiftIn = 1'b0; InValid = 1'b0; OutReady = 1'b0;
        #12;
        check("reset out_valid", 32'(OutValid), 32'd0);
        check("reset out", Out, 32'd0);
        check("reset in_ready", 32'(InReady), 32'd1);
        #5 Reset_n = 1'b1;
        OutReady = 1'b1;

        for (int i = 0; i < 10; i++) run_vec($sformatf("vec%0d", i), vecs[i]);

        // Stream of 8 with a 3-cycle downstream stall on the first result.
        fork
            begin
                int idx = 1;
                int guard = 0;
                while (idx <= 8 && guard < 60) begin
                    @(negedge Clock);
                    InValid = 1'b1; In = 32'(idx) << 8; ShiftAmount = 5'd8; ShiftIn = 1'b0;
                    #3 acc = InReady;
                    @(posedge Clock);
                    if (acc) idx++;
                    guard++;
                end
                #1 InValid = 1'b0;
            end
            begin
                int stall = 0;
                bit stall_done = 0;
                for (int c = 0; c < 60 && got.size() < 8; c++) begin
                    @(negedge Clock); #1;
                    if (OutValid && !stall_done) begin
                        stall = 3; stall_done = 1; held = Out;
                    end
                    OutReady = (stall == 0);
                    #1;
                    if (stall > 0) begin
                        check("stall in_ready", 32'(InReady), 32'd0);
                        check("stall out_valid", 32'(OutValid), 32'd1);
                        check("stall out held", Out, held);
                        stall--;
                    end else if (OutValid) begin
                        got.push_back(Out);
                    end
                end
                OutReady = 1'b1;
            end
        join
        check("stream count", 32'(got.size()), 32'd8);
        for (int i = 0; i < 8; i++)
            check($sformatf("stream out%0d", i + 1), (i < got.size()) ? got[i] : 32'hxxxx_xxxx, 32'(i + 1));
        repeat (3) @(posedge Clock);

        // Three in flight, then an asynchronous reset pulse mid-cycle.
        for (int k = 1; k <= 3; k++) begin
            @(negedge Clock);
            InValid = 1'b1; In = 32'(k) << 8; ShiftAmount = 5'd8; ShiftIn = 1'b0;
            @(posedge Clock);
        end
        #1 InValid = 1'b0;
        @(posedge Clock);
        @(posedge Clock); #1;
        check("pre-reset out_valid", 32'(OutValid), 32'd1);
        check("pre-reset out", Out, 32'd1);
        #1 Reset_n = 1'b0;
        #1;
        check("async reset out_valid", 32'(OutValid), 32'd0);
        check("async reset out", Out, 32'd0);
        check("async reset in_ready", 32'(InReady), 32'd1);
        #4 Reset_n = 1'b1;
        saw = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(posedge Clock); #1;
            if (OutValid) saw = 1'b1;
        end
        check("no stale after reset", 32'(saw), 32'd0);
        run_vec("post-reset", '{32'h0000_AB00, 5'd8, 1'b0, 32'h0000_00AB, 1'b0});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
